// File: rtl/kernel_dispatch_queue.sv
// Descriptor FIFO that hands kernel launches (PC, thread count) to idle SIMD cores, round-robin.
// Optional `DISPATCH_AFFINITY_EN adds a per-descriptor core mask (enq_core_mask).
module kernel_dispatch_queue #(
    parameter int NUM_SIMD_CORES    = 4,
    parameter int THREAD_COUNT      = 8,
    parameter int LOG2_THREAD_COUNT = 3,
    parameter int QUEUE_DEPTH       = 8,
    parameter int PC_WIDTH          = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enq_valid,
    output logic                              enq_ready,
    input  logic [PC_WIDTH-1:0]               enq_pc,
    input  logic [LOG2_THREAD_COUNT:0]        enq_threads,
`ifdef DISPATCH_AFFINITY_EN
    input  logic [NUM_SIMD_CORES-1:0]         enq_core_mask,
`endif
    input  logic                              launch_en,
    input  logic [NUM_SIMD_CORES-1:0]         core_done,
    output logic [NUM_SIMD_CORES-1:0]         core_launch,
    output logic [PC_WIDTH-1:0]               core_pc,
    output logic [LOG2_THREAD_COUNT:0]        core_threads,
    output logic [NUM_SIMD_CORES-1:0]         core_busy,
    output logic [$clog2(QUEUE_DEPTH):0]      queue_count,
    output logic                              queue_full,
    output logic                              queue_empty,
    output logic                              err_bad_desc
);
    localparam int PTR_W  = $clog2(QUEUE_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int CORE_W = (NUM_SIMD_CORES > 1) ? $clog2(NUM_SIMD_CORES) : 1;
    localparam int THR_W  = LOG2_THREAD_COUNT + 1;

    typedef enum logic {CORE_IDLE, CORE_BUSY} core_state_e;

    core_state_e core_state_q [NUM_SIMD_CORES];
    core_state_e core_state_d [NUM_SIMD_CORES];

    logic [PC_WIDTH-1:0] pc_mem  [QUEUE_DEPTH];
    logic [THR_W-1:0]    thr_mem [QUEUE_DEPTH];
`ifdef DISPATCH_AFFINITY_EN
    logic [NUM_SIMD_CORES-1:0] mask_mem [QUEUE_DEPTH];
`endif

    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [CORE_W-1:0]         rr_q, rr_d;
    logic [NUM_SIMD_CORES-1:0] launch_q, launch_d;
    logic [PC_WIDTH-1:0]       pc_q, pc_d;
    logic [THR_W-1:0]          thr_q, thr_d;
    logic                      err_q, err_d;

    logic                      desc_ok, enq_fire, push, pop;
    logic [NUM_SIMD_CORES-1:0] eligible;
    logic                      sel_found;
    logic [CORE_W-1:0]         sel_idx, cand_idx;
    int                        cand;

    assign queue_full  = (count_q == CNT_W'(QUEUE_DEPTH));
    assign queue_empty = (count_q == '0);
    assign enq_ready   = !queue_full;
    assign queue_count = count_q;
    assign core_launch = launch_q;
    assign core_pc     = pc_q;
    assign core_threads = thr_q;
    assign err_bad_desc = err_q;

    // Illegal descriptors are consumed (handshake completes) but never written.
    always_comb begin
        desc_ok = (enq_threads != '0) && (enq_threads <= THR_W'(THREAD_COUNT));
`ifdef DISPATCH_AFFINITY_EN
        desc_ok = desc_ok && (enq_core_mask != '0);
`endif
        enq_fire = enq_valid && enq_ready;
        push     = enq_fire && desc_ok;
    end

    always_comb begin
        for (int i = 0; i < NUM_SIMD_CORES; i++) begin
            core_busy[i] = (core_state_q[i] == CORE_BUSY);
        end
    end

    // Round-robin search for the first eligible core starting at rr_q.
    always_comb begin
        eligible = ~core_busy;
`ifdef DISPATCH_AFFINITY_EN
        eligible = eligible & mask_mem[rd_ptr_q];
`endif
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_SIMD_CORES; k++) begin
            cand = int'(rr_q) + k;
            if (cand >= NUM_SIMD_CORES) begin
                cand = cand - NUM_SIMD_CORES;
            end
            cand_idx = CORE_W'(cand);
            if (!sel_found && eligible[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        pop      = launch_en && !queue_empty && sel_found;
        launch_d = '0;
        pc_d     = pc_q;
        thr_d    = thr_q;
        rr_d     = rr_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        err_d    = err_q || (enq_fire && !desc_ok);
        if (pop) begin
            launch_d = NUM_SIMD_CORES'(1) << sel_idx;
            pc_d     = pc_mem[rd_ptr_q];
            thr_d    = thr_mem[rd_ptr_q];
            rr_d     = (sel_idx == CORE_W'(NUM_SIMD_CORES - 1)) ? '0 : sel_idx + 1'b1;
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Core goes BUSY on the same edge its launch pulse is registered, so it can't be picked twice.
    always_comb begin
        for (int i = 0; i < NUM_SIMD_CORES; i++) begin
            core_state_d[i] = core_state_q[i];
            case (core_state_q[i])
                CORE_IDLE: if (launch_d[i])  core_state_d[i] = CORE_BUSY;
                CORE_BUSY: if (core_done[i]) core_state_d[i] = CORE_IDLE;
                default:                     core_state_d[i] = CORE_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SIMD_CORES; i++) begin
                core_state_q[i] <= CORE_IDLE;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_q     <= '0;
            launch_q <= '0;
            pc_q     <= '0;
            thr_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SIMD_CORES; i++) begin
                core_state_q[i] <= core_state_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rr_q     <= rr_d;
            launch_q <= launch_d;
            pc_q     <= pc_d;
            thr_q    <= thr_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= enq_pc;
            thr_mem[wr_ptr_q]  <= enq_threads;
`ifdef DISPATCH_AFFINITY_EN
            mask_mem[wr_ptr_q] <= enq_core_mask;
`endif
        end
    end
endmodule

// File: tb/tb_kernel_dispatch_queue.sv
// Directed bench for kernel_dispatch_queue; builds with or without DISPATCH_AFFINITY_EN.
module tb_kernel_dispatch_queue;
  localparam int N  = 4;
  localparam int PW = 32;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enq_valid = 1'b0;
  logic          enq_ready;
  logic [PW-1:0] enq_pc = '0;
  logic [TW-1:0] enq_threads = '0;
  logic [N-1:0]  enq_core_mask = 4'hF;
  logic          launch_en = 1'b0;
  logic [N-1:0]  core_done = '0;
  logic [N-1:0]  core_launch;
  logic [PW-1:0] core_pc;
  logic [TW-1:0] core_threads;
  logic [N-1:0]  core_busy;
  logic [3:0]    queue_count;
  logic          queue_full;
  logic          queue_empty;
  logic          err_bad_desc;

  int checks = 0;
  int errors = 0;

  kernel_dispatch_queue dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc), .enq_threads(enq_threads),
`ifdef DISPATCH_AFFINITY_EN
    .enq_core_mask(enq_core_mask),
`endif
    .launch_en(launch_en), .core_done(core_done),
    .core_launch(core_launch), .core_pc(core_pc), .core_threads(core_threads),
    .core_busy(core_busy), .queue_count(queue_count), .queue_full(queue_full),
    .queue_empty(queue_empty), .err_bad_desc(err_bad_desc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    enq_valid = 1'b0;
    launch_en = 1'b0;
    core_done = '0;
    enq_core_mask = 4'hF;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic enq(input logic [PW-1:0] pc, input logic [TW-1:0] thr);
    enq_valid = 1'b1;
    enq_pc = pc;
    enq_threads = thr;
    step();
    enq_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (core_launch !== 4'h0) begin errors++; $display("FAIL reset_launch got %h exp 0", core_launch); end
    checks++; if (core_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", core_pc); end
    checks++; if (core_threads !== 4'h0) begin errors++; $display("FAIL reset_threads got %h exp 0", core_threads); end
    checks++; if (core_busy !== 4'h0) begin errors++; $display("FAIL reset_busy got %h exp 0", core_busy); end
    checks++; if (queue_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", queue_count); end
    checks++; if (queue_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", queue_full); end
    checks++; if (queue_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", queue_empty); end
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", enq_ready); end
    checks++; if (err_bad_desc !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_bad_desc); end
  endtask

  task automatic test_backlog();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      enq(32'h100 + i, TW'(i + 1));
      checks++; if (core_launch !== 4'h0) begin errors++; $display("FAIL backlog_nolaunch[%0d] got %h exp 0", i, core_launch); end
    end
    checks++; if (queue_count !== 4'd6) begin errors++; $display("FAIL backlog_count got %0d exp 6", queue_count); end
    launch_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (core_launch !== 4'(1 << c)) begin errors++; $display("FAIL backlog_core[%0d] got %h exp %h", c, core_launch, 4'(1 << c)); end
      checks++; if (core_pc !== 32'h100 + c) begin errors++; $display("FAIL backlog_pc[%0d] got %h exp %h", c, core_pc, 32'h100 + c); end
      checks++; if (core_threads !== TW'(c + 1)) begin errors++; $display("FAIL backlog_thr[%0d] got %0d exp %0d", c, core_threads, c + 1); end
    end
    checks++; if (queue_count !== 4'd2) begin errors++; $display("FAIL backlog_count2 got %0d exp 2", queue_count); end
    step();
    checks++; if (core_launch !== 4'h0) begin errors++; $display("FAIL backlog_allbusy_launch got %h exp 0", core_launch); end
    checks++; if (core_pc !== 32'h103) begin errors++; $display("FAIL backlog_pc_hold got %h exp 103", core_pc); end
    checks++; if (core_busy !== 4'hF) begin errors++; $display("FAIL backlog_busy got %h exp f", core_busy); end
    checks++; if (queue_count !== 4'd2) begin errors++; $display("FAIL backlog_count3 got %0d exp 2", queue_count); end
    launch_en = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) enq(32'h200 + i, TW'(i + 1));
    checks++; if (queue_full !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", queue_full); end
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", enq_ready); end
    checks++; if (queue_count !== 4'd8) begin errors++; $display("FAIL full_count got %0d exp 8", queue_count); end
    enq_valid = 1'b1; enq_pc = 32'hDEAD; enq_threads = 4'd1;
    step();
    checks++; if (queue_count !== 4'd8) begin errors++; $display("FAIL full_ninth got %0d exp 8", queue_count); end
    launch_en = 1'b1;
    step();
    checks++; if (core_launch !== 4'h1 || core_pc !== 32'h200) begin errors++; $display("FAIL full_pop0 got %h/%h exp 1/200", core_launch, core_pc); end
    checks++; if (queue_count !== 4'd7) begin errors++; $display("FAIL full_nobypass got %0d exp 7", queue_count); end
    enq_pc = 32'h2FF;
    step();
    enq_valid = 1'b0;
    checks++; if (core_launch !== 4'h2 || core_pc !== 32'h201) begin errors++; $display("FAIL full_pop1 got %h/%h exp 2/201", core_launch, core_pc); end
    checks++; if (queue_count !== 4'd7) begin errors++; $display("FAIL full_enqdeq got %0d exp 7", queue_count); end
    step();
    step();
    checks++; if (core_launch !== 4'h8 || core_pc !== 32'h203) begin errors++; $display("FAIL full_pop3 got %h/%h exp 8/203", core_launch, core_pc); end
    checks++; if (queue_count !== 4'd5) begin errors++; $display("FAIL full_count5 got %0d exp 5", queue_count); end
    core_done = 4'hF;
    step();
    core_done = 4'h0;
    checks++; if (core_launch !== 4'h0 || core_busy !== 4'h0) begin errors++; $display("FAIL full_release got %h/%h exp 0/0", core_launch, core_busy); end
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (core_launch !== 4'(1 << c) || core_pc !== 32'h204 + c) begin errors++; $display("FAIL full_round2[%0d] got %h/%h exp %h/%h", c, core_launch, core_pc, 4'(1 << c), 32'h204 + c); end
    end
    core_done = 4'hF;
    step();
    core_done = 4'h0;
    step();
    checks++; if (core_launch !== 4'h1 || core_pc !== 32'h2FF || core_threads !== 4'd1) begin errors++; $display("FAIL full_wrap got %h/%h/%0d exp 1/2ff/1", core_launch, core_pc, core_threads); end
    checks++; if (queue_empty !== 1'b1) begin errors++; $display("FAIL full_drained got %b exp 1", queue_empty); end
    launch_en = 1'b0;
  endtask

  task automatic test_core_release();
    do_reset();
    for (int i = 0; i < 4; i++) enq(32'h300 + i, 4'd1);
    enq(32'h8765_4321, 4'd2);
    launch_en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++; if (core_launch !== 4'h0 || core_busy !== 4'hF) begin errors++; $display("FAIL release_allbusy got %h/%h exp 0/f", core_launch, core_busy); end
    core_done = 4'h4;
    step();
    core_done = 4'h0;
    checks++; if (core_busy !== 4'hB) begin errors++; $display("FAIL release_busy got %h exp b", core_busy); end
    checks++; if (core_launch !== 4'h0) begin errors++; $display("FAIL release_same_cycle got %h exp 0", core_launch); end
    step();
    checks++; if (core_launch !== 4'h4) begin errors++; $display("FAIL release_core got %h exp 4", core_launch); end
    checks++; if (core_pc !== 32'h8765_4321 || core_threads !== 4'd2) begin errors++; $display("FAIL release_desc got %h/%0d exp 87654321/2", core_pc, core_threads); end
    checks++; if (queue_count !== 4'd0) begin errors++; $display("FAIL release_count got %0d exp 0", queue_count); end
    launch_en = 1'b0;
  endtask

  task automatic test_bad_desc();
    do_reset();
    enq(32'h400, 4'd0);
    enq(32'h401, 4'd9);
    checks++; if (queue_count !== 4'd0) begin errors++; $display("FAIL bad_count got %0d exp 0", queue_count); end
    checks++; if (err_bad_desc !== 1'b1) begin errors++; $display("FAIL bad_err got %b exp 1", err_bad_desc); end
    enq(32'h402, 4'd3);
    checks++; if (queue_count !== 4'd1 || err_bad_desc !== 1'b1) begin errors++; $display("FAIL bad_sticky got %0d/%b exp 1/1", queue_count, err_bad_desc); end
    core_done = 4'hF;
    step();
    core_done = 4'h0;
    checks++; if (core_busy !== 4'h0) begin errors++; $display("FAIL idle_done got %h exp 0", core_busy); end
    launch_en = 1'b1;
    step();
    checks++; if (core_launch !== 4'h1 || core_pc !== 32'h402 || core_threads !== 4'd3) begin errors++; $display("FAIL bad_good_launch got %h/%h/%0d exp 1/402/3", core_launch, core_pc, core_threads); end
    launch_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 7; i++) enq(32'h500 + i, 4'd2);
    launch_en = 1'b1;
    step(); step(); step();
    launch_en = 1'b0;
    checks++; if (core_busy !== 4'h7 || queue_count !== 4'd4) begin errors++; $display("FAIL mid_setup got %h/%0d exp 7/4", core_busy, queue_count); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (core_launch !== 4'h0 || core_busy !== 4'h0) begin errors++; $display("FAIL mid_core got %h/%h exp 0/0", core_launch, core_busy); end
    checks++; if (queue_count !== 4'd0 || queue_empty !== 1'b1 || enq_ready !== 1'b1) begin errors++; $display("FAIL mid_queue got %0d/%b/%b exp 0/1/1", queue_count, queue_empty, enq_ready); end
    checks++; if (core_pc !== 32'h0 || core_threads !== 4'h0) begin errors++; $display("FAIL mid_desc got %h/%0d exp 0/0", core_pc, core_threads); end
    step();
    rst = 1'b1;
    launch_en = 1'b1;
    step();
    checks++; if (core_launch !== 4'h0) begin errors++; $display("FAIL mid_after got %h exp 0", core_launch); end
    launch_en = 1'b0;
  endtask

`ifdef DISPATCH_AFFINITY_EN
  task automatic test_affinity();
    do_reset();
    enq_core_mask = 4'h8;
    enq(32'hA, 4'd1);
    enq(32'hB, 4'd1);
    launch_en = 1'b1;
    step();
    checks++; if (core_launch !== 4'h8 || core_pc !== 32'hA) begin errors++; $display("FAIL aff_first got %h/%h exp 8/a", core_launch, core_pc); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (core_launch !== 4'h0) begin errors++; $display("FAIL aff_block[%0d] got %h exp 0", i, core_launch); end
    end
    checks++; if (core_busy !== 4'h8 || queue_count !== 4'd1) begin errors++; $display("FAIL aff_state got %h/%0d exp 8/1", core_busy, queue_count); end
    core_done = 4'h8;
    step();
    core_done = 4'h0;
    step();
    checks++; if (core_launch !== 4'h8 || core_pc !== 32'hB) begin errors++; $display("FAIL aff_release got %h/%h exp 8/b", core_launch, core_pc); end
    launch_en = 1'b0;
    enq_core_mask = 4'h0;
    enq(32'hC, 4'd1);
    checks++; if (err_bad_desc !== 1'b1 || queue_count !== 4'd0) begin errors++; $display("FAIL aff_zero_mask got %b/%0d exp 1/0", err_bad_desc, queue_count); end
    enq_core_mask = 4'hF;
  endtask
`endif

  initial begin
    test_reset();
    test_backlog();
    test_full();
    test_core_release();
    test_bad_desc();
    test_reset_mid();
`ifdef DISPATCH_AFFINITY_EN
    test_affinity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
